// File: rtl/coeff_pkg.sv
// Shared constants and state encoding for the coefficient load path.
// Also used by bram2coeff.
package coeff_pkg;
   localparam int NUM_COEFF  = 25;
   localparam int KERNEL_DIM = 5;
   localparam int COEFF_W    = 16;
   localparam int BUS_W      = 32;
   localparam int BRAM_AW    = 5;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SEND,
      DONE
   } state_t;
endpackage

// File: rtl/coeff_stream_tx_if.sv
// Address/data valid-ready channel pair into the coefficient bank.
// The transmitter is the master; the coefficient bank is the slave.
interface coeff_stream_tx_if;
   import coeff_pkg::*;

   logic [BUS_W-1:0] filter_addr;
   logic             filter_addr_valid;
   logic             filter_addr_ready;
   logic [BUS_W-1:0] filter_data;
   logic             filter_data_valid;
   logic             filter_data_ready;

   modport master (
      output filter_addr,
      output filter_addr_valid,
      input  filter_addr_ready,
      output filter_data,
      output filter_data_valid,
      input  filter_data_ready
   );

   modport slave (
      input  filter_addr,
      input  filter_addr_valid,
      output filter_addr_ready,
      input  filter_data,
      input  filter_data_valid,
      output filter_data_ready
   );
endinterface

// File: rtl/coeff_stream_tx_vr_chan_reg.sv
// One valid/ready output register; load arms it, a handshake
// drops valid and raises the sticky completion flag.
module vr_chan_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] dout,
   output logic         complete
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid    <= 1'b0;
         dout     <= '0;
         complete <= 1'b0;
      end else if (load) begin
         valid    <= 1'b1;
         dout     <= din;
         complete <= 1'b0;
      end else if (valid && ready) begin
         valid    <= 1'b0;
         complete <= 1'b1;
      end
   end
endmodule

// File: rtl/coeff_stream_tx.sv
// Reads a coefficient block from BRAM and streams it as
// (index, sign-extended value) pairs over two channels.
module coeff_stream_tx #(
   parameter int NUM_COEFF = coeff_pkg::NUM_COEFF,
   parameter int BRAM_AW   = coeff_pkg::BRAM_AW,
   parameter int COEFF_W   = coeff_pkg::COEFF_W,
   parameter int BUS_W     = coeff_pkg::BUS_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BRAM_AW-1:0] base_addr,
   output logic               busy,
   output logic               done,
   output logic               bram_en,
   output logic [BRAM_AW-1:0] bram_addr,
   input  logic [COEFF_W-1:0] bram_dout,
   coeff_stream_tx_if.master  fif
);
   import coeff_pkg::*;

   localparam int IDX_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_COEFF - 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [BRAM_AW-1:0] base_q;
   logic               load;
   logic               addr_cmp;
   logic               data_cmp;
   logic               addr_ok;
   logic               data_ok;
   logic [BUS_W-1:0]   addr_din;
   logic [BUS_W-1:0]   data_din;

   assign load     = (state == LOAD);
   assign addr_din = BUS_W'(idx);
   assign data_din = {{(BUS_W-COEFF_W){bram_dout[COEFF_W-1]}},
                      bram_dout};

   // A channel counts as finished if it completed earlier or is
   // completing on this edge; both may finish together.
   assign addr_ok = addr_cmp
                  | (fif.filter_addr_valid & fif.filter_addr_ready);
   assign data_ok = data_cmp
                  | (fif.filter_data_valid & fif.filter_data_ready);

   vr_chan_reg #(.W(BUS_W)) u_addr (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .din      (addr_din),
      .ready    (fif.filter_addr_ready),
      .valid    (fif.filter_addr_valid),
      .dout     (fif.filter_addr),
      .complete (addr_cmp)
   );

   vr_chan_reg #(.W(BUS_W)) u_data (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .din      (data_din),
      .ready    (fif.filter_data_ready),
      .valid    (fif.filter_data_valid),
      .dout     (fif.filter_data),
      .complete (data_cmp)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= '0;
         base_q    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bram_en   <= 1'b0;
         bram_addr <= '0;
      end else begin
         done    <= 1'b0;
         bram_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  base_q    <= base_addr;
                  idx       <= '0;
                  busy      <= 1'b1;
                  bram_en   <= 1'b1;
                  bram_addr <= base_addr;
                  state     <= FETCH;
               end
            end
            FETCH: state <= LOAD;
            LOAD:  state <= SEND;
            SEND: begin
               if (addr_ok && data_ok) begin
                  if (idx == LAST) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx       <= idx + 1'b1;
                     bram_en   <= 1'b1;
                     // address wraps naturally at 2^BRAM_AW
                     bram_addr <= base_q + BRAM_AW'(idx)
                                + BRAM_AW'(1);
                     state     <= FETCH;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_coeff_stream_tx.sv
// Randomized bench for coeff_stream_tx against a queue-based
// model of the expected BRAM reads and channel transfers.
module tb_coeff_stream_tx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  base_addr = 5'd0;
   logic        busy, done, bram_en;
   logic [4:0]  bram_addr;
   logic [15:0] bram_dout;
   logic [15:0] mem [32];

   coeff_stream_tx_if fif();

   coeff_stream_tx dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .busy      (busy),
      .done      (done),
      .bram_en   (bram_en),
      .bram_addr (bram_addr),
      .bram_dout (bram_dout),
      .fif       (fif)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

   int pass_cnt = 0;
   int tot_cnt  = 0;

   logic        model_active = 1'b0;
   logic [31:0] exp_a [$];
   logic [31:0] exp_d [$];
   logic [4:0]  exp_b [$];
   int          s_cyc = 0;
   int          d_n = 0;
   int          first_av_rel = -1;
   int          first_addr = -1;
   int          done_rel = -1;
   int          done_cnt = 0;
   int          pair_cnt = 0;
   logic [31:0] got_data [25];

   logic rnd_rdy = 1'b0;
   logic a_fix = 1'b1;
   logic d_fix = 1'b1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic fail_now(input string nm);
      tot_cnt++;
      $display("FAIL %s: event occurred, expected none", nm);
   endtask

   task automatic clear_model();
      exp_a.delete();
      exp_d.delete();
      exp_b.delete();
      model_active = 1'b0;
   endtask

   initial begin
      fif.filter_addr_ready = 1'b1;
      fif.filter_data_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         fif.filter_addr_ready = rnd_rdy ? 1'($urandom) : a_fix;
         fif.filter_data_ready = rnd_rdy ? 1'($urandom) : d_fix;
      end
   end

   // per-cycle comparison against the model queues
   logic        pav = 0, par = 0, pdv = 0, pdr = 0;
   logic [31:0] pa = 0, pd = 0;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         chk("busy", busy, model_active);
         if (!model_active)
            chk("idle_outs", {done, bram_en, fif.filter_addr_valid,
                              fif.filter_data_valid}, 0);
         if (pav && par) chk("addr_drop", fif.filter_addr_valid, 0);
         else if (pav)
            chk("addr_hold", {fif.filter_addr_valid, fif.filter_addr},
                {1'b1, pa});
         if (pdv && pdr) chk("data_drop", fif.filter_data_valid, 0);
         else if (pdv)
            chk("data_hold", {fif.filter_data_valid, fif.filter_data},
                {1'b1, pd});
         if (bram_en) begin
            if (exp_b.size() == 0) fail_now("bram_extra");
            else chk("bram_addr", bram_addr, exp_b.pop_front());
         end
         if (fif.filter_addr_valid && first_av_rel < 0)
            first_av_rel = cyc - s_cyc + 1;
         if (fif.filter_addr_valid && fif.filter_addr_ready) begin
            if (exp_a.size() == 0) fail_now("addr_extra");
            else begin
               if (first_addr < 0) first_addr = int'(fif.filter_addr);
               chk("filter_addr", fif.filter_addr, exp_a.pop_front());
            end
         end
         if (fif.filter_data_valid && fif.filter_data_ready) begin
            if (exp_d.size() == 0) fail_now("data_extra");
            else begin
               if (d_n < 25) got_data[d_n] = fif.filter_data;
               d_n++;
               pair_cnt++;
               chk("filter_data", fif.filter_data, exp_d.pop_front());
            end
         end
         if (done && model_active) begin
            done_cnt++;
            done_rel = cyc - s_cyc + 1;
            chk("done_drain", exp_a.size() + exp_d.size() + exp_b.size(), 0);
            model_active = 1'b0;
         end
         pav = fif.filter_addr_valid;
         par = fif.filter_addr_ready;
         pa  = fif.filter_addr;
         pdv = fif.filter_data_valid;
         pdr = fif.filter_data_ready;
         pd  = fif.filter_data;
      end else begin
         pav = 1'b0;
         pdv = 1'b0;
      end
   end

   task automatic do_start(input logic [4:0] b);
      logic [4:0]  ba;
      logic [15:0] m;
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      base_addr = 5'($urandom);
      if (!model_active) begin
         model_active = 1'b1;
         s_cyc = cyc;
         d_n = 0;
         first_av_rel = -1;
         first_addr = -1;
         done_rel = -1;
         done_cnt = 0;
         pair_cnt = 0;
         for (int i = 0; i < 25; i++) begin
            ba = 5'(int'(b) + i);
            m = mem[ba];
            exp_a.push_back(32'(i));
            exp_b.push_back(ba);
            exp_d.push_back({{16{m[15]}}, m});
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 5'($urandom);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (model_active && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (model_active) begin
         fail_now("done_timeout");
         clear_model();
      end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      logic found;
      #1 rst = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bram_en", bram_en, 0);
      chk("rst_bram_addr", bram_addr, 0);
      chk("rst_valids", {fif.filter_addr_valid, fif.filter_data_valid}, 0);
      chk("rst_buses", {fif.filter_addr, fif.filter_data}, 0);
      #19 rst = 1'b1;

      for (int j = 0; j < 32; j++) mem[j] = 16'(j + 10);
      do_start(5'd0);
      wait_idle(300);
      chk("t1_first_valid_cycle", first_av_rel, 3);
      chk("t1_done_cycle", done_rel, 76);
      chk("t1_data0", got_data[0], 32'd10);
      chk("t1_data24", got_data[24], 32'd34);
      chk("t1_pairs", pair_cnt, 25);
      chk("t1_done_cnt", done_cnt, 1);

      mem[3] = 16'hFF80;
      mem[4] = 16'h7FFF;
      do_start(5'd0);
      while (cyc < s_cyc + 4) @(posedge clk);
      pulse_start();
      while (cyc < s_cyc + 39) @(posedge clk);
      pulse_start();
      wait_idle(300);
      chk("t2_sext_neg", got_data[3], 32'hFFFFFF80);
      chk("t2_sext_pos", got_data[4], 32'h00007FFF);
      chk("t2_pairs", pair_cnt, 25);
      chk("t2_done_cnt", done_cnt, 1);
      chk("t2_done_cycle", done_rel, 76);

      repeat (3) @(posedge clk);
      a_fix = 1'b1;
      d_fix = 1'b0;
      repeat (2) @(posedge clk);
      do_start(5'd7);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (fif.filter_data_valid) found = 1'b1;
      end
      if (!found) fail_now("bp_no_valid");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_addr_low", fif.filter_addr_valid, 0);
         chk("bp_data_high", fif.filter_data_valid, 1);
         chk("bp_no_fetch", bram_en, 0);
      end
      d_fix = 1'b1;
      wait_idle(500);
      chk("t3_pairs", pair_cnt, 25);

      rnd_rdy = 1'b1;
      for (int j = 0; j < 32; j++) mem[j] = 16'($urandom);
      do_start(5'd20);
      wait_idle(3000);
      chk("t4_wrap_pairs", pair_cnt, 25);

      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 32; j++) mem[j] = 16'($urandom);
         do_start(5'($urandom));
         wait_idle(3000);
         chk("t5_pairs", pair_cnt, 25);
         chk("t5_done_cnt", done_cnt, 1);
      end

      rnd_rdy = 1'b0;
      a_fix = 1'b1;
      d_fix = 1'b1;
      repeat (2) @(posedge clk);
      do_start(5'd3);
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (fif.filter_addr_valid && fif.filter_addr == 32'd12)
            found = 1'b1;
      end
      if (!found) fail_now("t6_no_idx12");
      #2 rst = 1'b0;
      #1;
      chk("t6_valids", {fif.filter_addr_valid, fif.filter_data_valid}, 0);
      chk("t6_busy", busy, 0);
      chk("t6_bram_en", bram_en, 0);
      clear_model();
      #23 rst = 1'b1;
      repeat (3) @(posedge clk);
      do_start(5'd9);
      wait_idle(300);
      chk("t6_first_index", first_addr, 0);
      chk("t6_pairs", pair_cnt, 25);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
